// File: rtl/fft_sample_store.sv
// fft_sample_store: holds one frame of samples written by the bridge and
// streams it to the FFT core in bit-reversed order. It then stores the core's
// results in natural order for the bridge to read back.
module fft_sample_store #(
   parameter int DEPTH_LOG2 = 12,
   parameter int SAMPLE_W   = 16,
   parameter int RESULT_W   = 32
) (
   input  logic                i_clk,
   input  logic                i_rstn,
   input  logic [3:0]          i_LOG2_N,
   input  logic [SAMPLE_W-1:0] i_SAMPLE,
   input  logic [11:0]         i_SAMPLE_INDEX,
   input  logic                i_WRITE,
   input  logic                i_READ,
   input  logic                i_DATA_LOADED,
   output logic [RESULT_W-1:0] o_DATA_TO_BRIDGE,
   output logic                o_CALC_END,
   output logic [11:0]         o_SAMPLES_NUMBER,
   output logic [SAMPLE_W-1:0] o_FFT_DATA,
   output logic                o_FFT_VALID,
   output logic                o_FFT_LAST,
   input  logic                i_FFT_READY,
   input  logic [RESULT_W-1:0] i_RES_DATA,
   input  logic                i_RES_VALID,
   input  logic                i_RES_LAST,
   output logic                o_RES_READY,
   output logic                o_FRAME_ERR
);

   typedef enum logic [1:0] {LOAD, FEED, COLLECT, DONE} state_t;

   localparam int MEM_DEPTH = 1 << DEPTH_LOG2;

   state_t                state_q, state_d;
   logic [3:0]            log2n_q, log2n_d;
   logic [12:0]           feedCnt_q, feedCnt_d;
   logic [12:0]           resCnt_q, resCnt_d;

   logic [SAMPLE_W-1:0]   smem [MEM_DEPTH];
   logic [RESULT_W-1:0]   rmem [MEM_DEPTH];

   logic [12:0]           nMinus1;
   logic [3:0]            newLog2n;
   logic [DEPTH_LOG2-1:0] bridgeAddr;
   logic [DEPTH_LOG2-1:0] revFull;
   logic [DEPTH_LOG2-1:0] feedAddr;
   logic [DEPTH_LOG2-1:0] resAddr;
   logic                  smemWe;
   logic                  rmemWe;
   logic                  resAtCount;

   assign nMinus1          = (13'd1 << log2n_q) - 13'd1;
   assign o_SAMPLES_NUMBER = nMinus1[11:0];
   assign bridgeAddr       = i_SAMPLE_INDEX[DEPTH_LOG2-1:0];
   assign resAddr          = resCnt_q[DEPTH_LOG2-1:0];
   assign resAtCount       = (resCnt_q == nMinus1);

   // A requested exponent of 0 still means a 2-point frame, and anything
   // larger than the memory clamps to the full memory.
   always_comb begin
      newLog2n = i_LOG2_N;
      if (i_LOG2_N == 4'd0) begin
         newLog2n = 4'd1;
      end else if (i_LOG2_N > 4'(DEPTH_LOG2)) begin
         newLog2n = 4'(DEPTH_LOG2);
      end
   end

   // Bit-reverse the feed counter over the full memory width and then shift
   // it down so that only the low L bits are reversed.
   always_comb begin
      revFull = '0;
      for (int i = 0; i < DEPTH_LOG2; i++) begin
         revFull[i] = feedCnt_q[DEPTH_LOG2-1-i];
      end
   end

   assign feedAddr   = revFull >> (4'(DEPTH_LOG2) - log2n_q);
   assign o_FFT_DATA = smem[feedAddr];

   // State register, latched frame exponent and both beat counters.
   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         state_q   <= LOAD;
         log2n_q   <= 4'(DEPTH_LOG2);
         feedCnt_q <= '0;
         resCnt_q  <= '0;
      end else begin
         state_q   <= state_d;
         log2n_q   <= log2n_d;
         feedCnt_q <= feedCnt_d;
         resCnt_q  <= resCnt_d;
      end
   end

   // Next-state logic, memory write enables and all status outputs.
   always_comb begin
      state_d          = state_q;
      log2n_d          = log2n_q;
      feedCnt_d        = feedCnt_q;
      resCnt_d         = resCnt_q;
      smemWe           = 1'b0;
      rmemWe           = 1'b0;
      o_FFT_VALID      = 1'b0;
      o_FFT_LAST       = 1'b0;
      o_RES_READY      = 1'b0;
      o_CALC_END       = 1'b0;
      o_FRAME_ERR      = 1'b0;
      o_DATA_TO_BRIDGE = '0;
      case (state_q)
         LOAD: begin
            smemWe = i_WRITE;
            if (i_DATA_LOADED) begin
               log2n_d   = newLog2n;
               feedCnt_d = '0;
               state_d   = FEED;
            end
         end
         FEED: begin
            o_FFT_VALID = 1'b1;
            o_FFT_LAST  = (feedCnt_q == nMinus1);
            if (i_FFT_READY) begin
               feedCnt_d = feedCnt_q + 13'd1;
               if (feedCnt_q == nMinus1) begin
                  resCnt_d = '0;
                  state_d  = COLLECT;
               end
            end
         end
         COLLECT: begin
            o_RES_READY = 1'b1;
            if (i_RES_VALID) begin
               rmemWe   = 1'b1;
               resCnt_d = resCnt_q + 13'd1;
               if (resAtCount || i_RES_LAST) begin
                  state_d = DONE;
               end
               o_FRAME_ERR = resAtCount ^ i_RES_LAST;
            end
         end
         DONE: begin
            o_CALC_END = 1'b1;
            if (i_READ) begin
               o_DATA_TO_BRIDGE = rmem[bridgeAddr];
            end
            if (i_WRITE) begin
               smemWe  = 1'b1;
               state_d = LOAD;
            end else if (i_DATA_LOADED) begin
               log2n_d   = newLog2n;
               feedCnt_d = '0;
               state_d   = FEED;
            end
         end
         default: state_d = LOAD;
      endcase
   end

   // Sample memory: synchronous write from the bridge, never reset.
   always_ff @(posedge i_clk) begin
      if (smemWe) begin
         smem[bridgeAddr] <= i_SAMPLE;
      end
   end

   // Result memory: synchronous write from the core, never reset.
   always_ff @(posedge i_clk) begin
      if (rmemWe) begin
         rmem[resAddr] <= i_RES_DATA;
      end
   end

endmodule

// File: tb/tb_fft_sample_store.sv
// Randomized self-checking bench for fft_sample_store with a frame-level
// reference model of both memories.
module tb_fft_sample_store;

   localparam int DL   = 12;
   localparam int SW   = 16;
   localparam int RW   = 32;
   localparam int MAXN = 1 << DL;

   logic          i_clk = 1'b0;
   logic          i_rstn;
   logic [3:0]    i_LOG2_N;
   logic [SW-1:0] i_SAMPLE;
   logic [11:0]   i_SAMPLE_INDEX;
   logic          i_WRITE;
   logic          i_READ;
   logic          i_DATA_LOADED;
   logic [RW-1:0] o_DATA_TO_BRIDGE;
   logic          o_CALC_END;
   logic [11:0]   o_SAMPLES_NUMBER;
   logic [SW-1:0] o_FFT_DATA;
   logic          o_FFT_VALID;
   logic          o_FFT_LAST;
   logic          i_FFT_READY;
   logic [RW-1:0] i_RES_DATA;
   logic          i_RES_VALID;
   logic          i_RES_LAST;
   logic          o_RES_READY;
   logic          o_FRAME_ERR;

   int checks = 0;
   int errors = 0;

   logic [SW-1:0] smemModel [MAXN];
   logic [RW-1:0] rmemModel [MAXN];

   fft_sample_store #(.DEPTH_LOG2(DL), .SAMPLE_W(SW), .RESULT_W(RW)) dut (
      .i_clk            (i_clk),
      .i_rstn           (i_rstn),
      .i_LOG2_N         (i_LOG2_N),
      .i_SAMPLE         (i_SAMPLE),
      .i_SAMPLE_INDEX   (i_SAMPLE_INDEX),
      .i_WRITE          (i_WRITE),
      .i_READ           (i_READ),
      .i_DATA_LOADED    (i_DATA_LOADED),
      .o_DATA_TO_BRIDGE (o_DATA_TO_BRIDGE),
      .o_CALC_END       (o_CALC_END),
      .o_SAMPLES_NUMBER (o_SAMPLES_NUMBER),
      .o_FFT_DATA       (o_FFT_DATA),
      .o_FFT_VALID      (o_FFT_VALID),
      .o_FFT_LAST       (o_FFT_LAST),
      .i_FFT_READY      (i_FFT_READY),
      .i_RES_DATA       (i_RES_DATA),
      .i_RES_VALID      (i_RES_VALID),
      .i_RES_LAST       (i_RES_LAST),
      .o_RES_READY      (o_RES_READY),
      .o_FRAME_ERR      (o_FRAME_ERR)
   );

   always #5 i_clk = ~i_clk;

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   function automatic int effLog2(input int l);
      if (l == 0) return 1;
      if (l > DL) return DL;
      return l;
   endfunction

   function automatic int bitrev(input int k, input int l);
      int r = 0;
      for (int i = 0; i < l; i++) begin
         if (((k >> (l - 1 - i)) & 1) != 0) r = r | (1 << i);
      end
      return r;
   endfunction

   task automatic tick;
      @(posedge i_clk);
      @(negedge i_clk);
   endtask

   task automatic idleInputs;
      i_WRITE        = 1'b0;
      i_READ         = 1'b0;
      i_DATA_LOADED  = 1'b0;
      i_FFT_READY    = 1'b0;
      i_RES_VALID    = 1'b0;
      i_RES_LAST     = 1'b0;
      i_SAMPLE       = '0;
      i_SAMPLE_INDEX = '0;
      i_RES_DATA     = '0;
   endtask

   // Writes a full frame in LOAD; the last write coincides with DATA_LOADED.
   task automatic applyStimulus(input int l, input bit rampPattern);
      int n = 1 << effLog2(l);
      for (int k = 0; k < n; k++) begin
         i_WRITE        = 1'b1;
         i_SAMPLE_INDEX = 12'(k);
         i_SAMPLE       = rampPattern ? SW'(16'h0010 * k) : SW'($urandom);
         smemModel[k]   = i_SAMPLE;
         i_DATA_LOADED  = (k == n - 1);
         i_LOG2_N       = 4'(l);
         tick();
      end
      idleInputs();
   endtask

   task automatic startFeed(input int l);
      i_DATA_LOADED = 1'b1;
      i_LOG2_N      = 4'(l);
      tick();
      idleInputs();
   endtask

   task automatic feedFrame(input int l, input bit randReady, input bit junk);
      int le  = effLog2(l);
      int n   = 1 << le;
      int j   = 0;
      int cyc = 0;
      #1;
      checkOutput("samplesNumber", 64'(o_SAMPLES_NUMBER), 64'(n - 1));
      while (j < n && cyc < 8 * n + 16) begin
         i_FFT_READY = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
         if (junk) begin
            i_WRITE        = 1'b1;
            i_READ         = 1'b1;
            i_SAMPLE_INDEX = 12'($urandom_range(0, MAXN - 1));
            i_SAMPLE       = SW'($urandom);
         end
         #1;
         checkOutput("fftValid", 64'(o_FFT_VALID), 64'd1);
         checkOutput("fftData", 64'(o_FFT_DATA), 64'(smemModel[bitrev(j, le)]));
         checkOutput("fftLast", 64'(o_FFT_LAST), 64'(j == n - 1));
         if (junk) checkOutput("bridgeInFeed", 64'(o_DATA_TO_BRIDGE), 64'd0);
         if (i_FFT_READY) j++;
         cyc++;
         tick();
      end
      checkOutput("feedBeats", 64'(j), 64'(n));
      idleInputs();
      #1;
      checkOutput("fftValidAfter", 64'(o_FFT_VALID), 64'd0);
      checkOutput("resReadyAfter", 64'(o_RES_READY), 64'd1);
   endtask

   // mode 0: LAST on the N-th result, 1: early LAST at earlyIdx, 2: no LAST.
   task automatic collectFrame(input int l, input int mode, input int earlyIdx,
                               input bit randValid, input bit seqData, output int accepted);
      int n     = 1 << effLog2(l);
      int k     = 0;
      int cyc   = 0;
      bit ended = 0;
      bit atCount;
      bit lastFlag;
      while (!ended && cyc < 4 * n + 16) begin
         atCount     = (k == n - 1);
         lastFlag    = (mode == 0 && k == n - 1) || (mode == 1 && k == earlyIdx);
         i_RES_VALID = randValid ? 1'($urandom_range(0, 1)) : 1'b1;
         i_RES_DATA  = seqData ? RW'(32'hA000_0000 + k) : RW'($urandom);
         i_RES_LAST  = lastFlag;
         i_READ      = 1'b1;
         #1;
         checkOutput("resReady", 64'(o_RES_READY), 64'd1);
         checkOutput("calcEndEarly", 64'(o_CALC_END), 64'd0);
         checkOutput("bridgeInCollect", 64'(o_DATA_TO_BRIDGE), 64'd0);
         checkOutput("frameErr", 64'(o_FRAME_ERR), 64'(i_RES_VALID && (atCount != lastFlag)));
         if (i_RES_VALID) begin
            rmemModel[k] = i_RES_DATA;
            k++;
            if (atCount || lastFlag) ended = 1;
         end
         cyc++;
         tick();
      end
      checkOutput("collectEnded", 64'(ended), 64'd1);
      idleInputs();
      #1;
      checkOutput("calcEnd", 64'(o_CALC_END), 64'd1);
      checkOutput("resReadyDone", 64'(o_RES_READY), 64'd0);
      checkOutput("frameErrDone", 64'(o_FRAME_ERR), 64'd0);
      accepted = k;
   endtask

   task automatic readBack(input int accepted);
      int idx;
      for (int r = 0; r < 6; r++) begin
         idx = (r == 0 && accepted > 5) ? 5 : $urandom_range(0, accepted - 1);
         i_SAMPLE_INDEX = 12'(idx);
         i_READ         = 1'b1;
         #1;
         checkOutput("readData", 64'(o_DATA_TO_BRIDGE), 64'(rmemModel[idx]));
         i_READ = 1'b0;
         #1;
         checkOutput("readIdle", 64'(o_DATA_TO_BRIDGE), 64'd0);
         tick();
      end
   endtask

   task automatic doneWrite(input int idx, input logic [SW-1:0] data);
      i_WRITE        = 1'b1;
      i_SAMPLE_INDEX = 12'(idx);
      i_SAMPLE       = data;
      smemModel[idx] = data;
      #1;
      checkOutput("calcEndBeforeWrite", 64'(o_CALC_END), 64'd1);
      tick();
      idleInputs();
      #1;
      checkOutput("calcEndAfterWrite", 64'(o_CALC_END), 64'd0);
      checkOutput("fftValidInLoad", 64'(o_FFT_VALID), 64'd0);
   endtask

   task automatic checkIdleOutputs(input string tag);
      checkOutput({tag, "Valid"}, 64'(o_FFT_VALID), 64'd0);
      checkOutput({tag, "Last"}, 64'(o_FFT_LAST), 64'd0);
      checkOutput({tag, "ResReady"}, 64'(o_RES_READY), 64'd0);
      checkOutput({tag, "CalcEnd"}, 64'(o_CALC_END), 64'd0);
      checkOutput({tag, "FrameErr"}, 64'(o_FRAME_ERR), 64'd0);
      checkOutput({tag, "Bridge"}, 64'(o_DATA_TO_BRIDGE), 64'd0);
      checkOutput({tag, "SamplesNumber"}, 64'(o_SAMPLES_NUMBER), 64'(MAXN - 1));
   endtask

   initial begin
      int acc;
      int l;
      int mode;
      int n;
      idleInputs();
      i_LOG2_N = 4'd0;
      i_rstn   = 1'b0;
      #12;
      checkIdleOutputs("reset");
      @(negedge i_clk);
      i_rstn = 1'b1;
      tick();
      checkIdleOutputs("postReset");

      // Ramp frame with continuous READY, then ordered results.
      applyStimulus(3, 1'b1);
      feedFrame(3, 1'b0, 1'b0);
      collectFrame(3, 0, 0, 1'b0, 1'b1, acc);
      readBack(acc);

      // Re-run on the stored frame with stalls and ignored bridge writes.
      startFeed(3);
      feedFrame(3, 1'b1, 1'b1);
      collectFrame(3, 1, 5, 1'b0, 1'b1, acc);
      checkOutput("earlyLastCount", 64'(acc), 64'd6);
      readBack(acc);

      startFeed(3);
      feedFrame(3, 1'b1, 1'b0);
      collectFrame(3, 2, 0, 1'b1, 1'b0, acc);
      readBack(acc);

      // Write from DONE returns to LOAD; a bare DATA_LOADED then feeds.
      doneWrite(2, 16'h1234);
      startFeed(3);
      feedFrame(3, 1'b0, 1'b0);
      collectFrame(3, 0, 0, 1'b1, 1'b0, acc);
      readBack(acc);

      // Random frames with random size (0 clamps to 1) and ending mode.
      for (int it = 0; it < 6; it++) begin
         doneWrite($urandom_range(0, MAXN - 1), SW'($urandom));
         l    = $urandom_range(0, 6);
         n    = 1 << effLog2(l);
         mode = $urandom_range(0, 2);
         applyStimulus(l, 1'b0);
         feedFrame(l, 1'b1, 1'b0);
         collectFrame(l, mode, $urandom_range(0, n - 2), 1'b1, 1'b0, acc);
         readBack(acc);
      end

      // Oversized exponent clamps to the full memory.
      doneWrite(0, SW'($urandom));
      applyStimulus(15, 1'b0);
      feedFrame(15, 1'b0, 1'b0);
      collectFrame(15, 0, 0, 1'b0, 1'b0, acc);
      readBack(acc);

      // Asynchronous reset in the middle of result collection.
      doneWrite(0, SW'($urandom));
      applyStimulus(2, 1'b0);
      feedFrame(2, 1'b0, 1'b0);
      i_RES_VALID = 1'b1;
      i_RES_DATA  = RW'($urandom);
      tick();
      #2;
      i_rstn = 1'b0;
      #1;
      checkIdleOutputs("midReset");
      idleInputs();
      @(negedge i_clk);
      i_rstn = 1'b1;
      tick();
      applyStimulus(2, 1'b0);
      feedFrame(2, 1'b1, 1'b0);
      collectFrame(2, 0, 0, 1'b1, 1'b0, acc);
      readBack(acc);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
